// File: rtl/rcn_dma_copy_pkg.sv
// Shared definitions for the rcn_dma_copy word-copy engine: FSM encoding,
// pointer step and the constant byte-enable mask.
package rcn_dma_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } dma_state_t;

  localparam int unsigned ADDR_STEP = 4;
  localparam logic [3:0]  FULL_MASK = 4'hF;

endpackage

// File: rtl/rcn_dma_fifo.sv
// DEPTH x 32 read-data buffer between read responses and write issue.
// Head word is presented combinationally on o_data.
module rcn_dma_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  output logic [31:0]   o_data,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_push, w_pop;

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rcn_dma_copy.sv
// Raccoon-bus DMA word copier: reads LEN words from SRC_ADDR, writes them to
// DST_ADDR. Define RCN_DMA_FILL_EN to add FILL/FILL_DATA constant-fill mode.
module rcn_dma_copy
  import rcn_dma_copy_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [LEN_W-1:0]  LEN,
`ifdef RCN_DMA_FILL_EN
  input  logic              FILL,
  input  logic [31:0]       FILL_DATA,
`endif
  output logic              BUSY,
  output logic              DONE,
  output logic              REQ_CS,
  input  logic              REQ_BUSY,
  output logic              REQ_WR,
  output logic [3:0]        REQ_MASK,
  output logic [ADDR_W-1:0] REQ_ADDR,
  output logic [31:0]       REQ_DATA,
  input  logic              RSP_VALID,
  input  logic              RSP_WR,
  input  logic [31:0]       RSP_DATA
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(3);

  dma_state_t        r_state;
  logic [LEN_W-1:0]  r_len, r_rd_iss, r_rd_ret, r_wr_iss, r_wr_ack;
  logic [ADDR_W-1:0] r_src, r_dst, r_req_addr;
  logic              r_busy, r_done, r_req_cs, r_req_wr;
  logic [31:0]       r_req_data;

  logic              w_fill, w_start_fill;
  logic [31:0]       w_fill_data;
`ifdef RCN_DMA_FILL_EN
  logic              r_fill;
  logic [31:0]       r_fill_data;
  assign w_fill       = r_fill;
  assign w_fill_data  = r_fill_data;
  assign w_start_fill = FILL;
`else
  assign w_fill       = 1'b0;
  assign w_fill_data  = 32'h0;
  assign w_start_fill = 1'b0;
`endif

  logic              w_active, w_slot, w_rsp_rd, w_rsp_wr;
  logic              w_wr_pend, w_rd_pend, w_do_wr, w_do_rd, w_pop, w_credit;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [31:0]       w_fifo_dout, w_wr_data;
  logic [LEN_W-1:0]  w_inflight, w_occ, w_outstanding;
  logic [ADDR_W-1:0] w_src_al, w_dst_al;

  assign w_src_al = SRC_ADDR & ALIGN;
  assign w_dst_al = DST_ADDR & ALIGN;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_slot   = ~r_req_cs | ~REQ_BUSY;
  assign w_rsp_rd = w_active & RSP_VALID & ~RSP_WR;
  assign w_rsp_wr = w_active & RSP_VALID &  RSP_WR;

  // Reads are also capped against unacknowledged writes, so reads issued
  // minus writes acknowledged never exceeds DEPTH.
  assign w_inflight    = r_rd_iss - r_rd_ret;
  assign w_occ         = LEN_W'(w_fifo_count);
  assign w_outstanding = r_rd_iss - r_wr_ack;
  assign w_credit      = ((w_inflight + w_occ) < DEPTH_L) && (w_outstanding < DEPTH_L);

  assign w_wr_pend = w_active && (r_wr_iss != r_len) && (w_fill || !w_fifo_empty);
  assign w_rd_pend = (r_state == ST_RUN) && !w_fill && (r_rd_iss != r_len) && w_credit;
  assign w_do_wr   = w_slot & w_wr_pend;
  assign w_do_rd   = w_slot & ~w_wr_pend & w_rd_pend;
  assign w_pop     = w_do_wr & ~w_fill;
  assign w_wr_data = w_fill ? w_fill_data : w_fifo_dout;

  rcn_dma_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_rsp_rd),
    .i_data  (RSP_DATA),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_rd_iss   <= '0;
      r_rd_ret   <= '0;
      r_wr_iss   <= '0;
      r_wr_ack   <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_req_cs   <= 1'b0;
      r_req_wr   <= 1'b0;
      r_req_addr <= '0;
      r_req_data <= '0;
`ifdef RCN_DMA_FILL_EN
      r_fill      <= 1'b0;
      r_fill_data <= '0;
`endif
    end else begin
      r_done <= 1'b0;

      // Request register only reloads once the current request is taken.
      if (w_do_wr) begin
        r_req_cs   <= 1'b1;
        r_req_wr   <= 1'b1;
        r_req_addr <= r_dst;
        r_req_data <= w_wr_data;
        r_dst      <= r_dst + STEP;
        r_wr_iss   <= r_wr_iss + 1'b1;
      end else if (w_do_rd) begin
        r_req_cs   <= 1'b1;
        r_req_wr   <= 1'b0;
        r_req_addr <= r_src;
        r_req_data <= '0;
        r_src      <= r_src + STEP;
        r_rd_iss   <= r_rd_iss + 1'b1;
      end else if (w_slot) begin
        r_req_cs   <= 1'b0;
      end

      if (w_rsp_rd) r_rd_ret <= r_rd_ret + 1'b1;
      if (w_rsp_wr) r_wr_ack <= r_wr_ack + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_busy   <= 1'b1;
            r_len    <= LEN;
            r_rd_ret <= '0;
            r_wr_iss <= '0;
            r_wr_ack <= '0;
            r_src    <= w_src_al;
            r_dst    <= w_dst_al;
            r_rd_iss <= '0;
`ifdef RCN_DMA_FILL_EN
            r_fill      <= FILL;
            r_fill_data <= FILL_DATA;
`endif
            if (LEN == '0) begin
              r_state <= ST_FIN;
            end else if (w_start_fill) begin
              r_state <= ST_DRAIN;
            end else begin
              // First read goes out straight from IDLE to save a cycle.
              r_req_cs   <= 1'b1;
              r_req_wr   <= 1'b0;
              r_req_addr <= w_src_al;
              r_req_data <= '0;
              r_src      <= w_src_al + STEP;
              r_rd_iss   <= LEN_W'(1);
              r_state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (r_rd_iss == r_len) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_wr_ack == r_len) r_state <= ST_FIN;
        end
        default: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign REQ_CS   = r_req_cs;
  assign REQ_WR   = r_req_wr;
  assign REQ_MASK = FULL_MASK;
  assign REQ_ADDR = r_req_addr;
  assign REQ_DATA = r_req_data;

endmodule

// File: tb/tb_rcn_dma_copy.sv
// Scoreboard bench for rcn_dma_copy: a 1-cycle memory slave model answers
// requests, a monitor pops expected requests as the DUT issues them.
module tb_rcn_dma_copy;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [19:0] SRC_ADDR = '0, DST_ADDR = '0;
  logic [15:0] LEN = '0;
  logic        BUSY, DONE, REQ_CS, REQ_WR;
  logic        REQ_BUSY = 1'b0;
  logic [3:0]  REQ_MASK;
  logic [19:0] REQ_ADDR;
  logic [31:0] REQ_DATA;
  logic        RSP_VALID = 1'b0, RSP_WR = 1'b0;
  logic [31:0] RSP_DATA = '0;
`ifdef RCN_DMA_FILL_EN
  logic        FILL = 1'b0;
  logic [31:0] FILL_DATA = '0;
`endif

  rcn_dma_copy #(.ADDR_W(20), .DEPTH(DEPTH), .LEN_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LEN(LEN),
`ifdef RCN_DMA_FILL_EN
    .FILL(FILL), .FILL_DATA(FILL_DATA),
`endif
    .BUSY(BUSY), .DONE(DONE),
    .REQ_CS(REQ_CS), .REQ_BUSY(REQ_BUSY), .REQ_WR(REQ_WR), .REQ_MASK(REQ_MASK),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_WR(RSP_WR), .RSP_DATA(RSP_DATA)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct { logic [19:0] a; logic [31:0] d; } wexp_t;

  int          n_chk = 0, n_pass = 0;
  logic [31:0] mem [logic [19:0]];
  logic [19:0] exp_rd_q [$];
  wexp_t       exp_wr_q [$];
  bit          bp_en = 0, gap_en = 0, inj = 0;
  int          rd_acc = 0, wr_acc = 0, ack_cnt = 0, done_cnt = 0;
  int          rd_base = 0, ack_base = 0, max_gap = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Random stall generator
  initial forever begin
    @(posedge CLK); #1;
    REQ_BUSY = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Memory slave: response appears in the cycle after acceptance
  initial begin : responder
    logic a, w, i;
    logic [19:0] ad;
    logic [31:0] d;
    forever begin
      @(negedge CLK);
      a = RST && REQ_CS && !REQ_BUSY;
      w = REQ_WR; ad = REQ_ADDR; d = REQ_DATA; i = inj;
      @(posedge CLK); #1;
      if (a && w) begin
        mem[ad] = d; ack_cnt++;
        RSP_VALID = 1'b1; RSP_WR = 1'b1; RSP_DATA = '0;
      end else if (a) begin
        RSP_VALID = 1'b1; RSP_WR = 1'b0;
        RSP_DATA = mem.exists(ad) ? mem[ad] : 32'h0;
      end else if (i) begin
        RSP_VALID = 1'b1; RSP_WR = 1'b0; RSP_DATA = 32'hBAD0BAD0;
      end else begin
        RSP_VALID = 1'b0; RSP_WR = 1'b0; RSP_DATA = '0;
      end
    end
  end

  // Monitor / scoreboard
  logic        prev_stall = 1'b0;
  logic [63:0] held = '0;
  wexp_t       we;
  logic [19:0] re;
  int          gap;
  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (RST && REQ_CS && !REQ_BUSY) begin
      check("req_mask", REQ_MASK, 4'hF);
      if (REQ_WR) begin
        wr_acc++;
        if (exp_wr_q.size() == 0) check("unexpected_write", REQ_ADDR, 64'hFFFFFFFF);
        else begin
          we = exp_wr_q.pop_front();
          check("wr_addr", REQ_ADDR, we.a);
          check("wr_data", REQ_DATA, we.d);
        end
      end else begin
        rd_acc++;
        if (exp_rd_q.size() == 0) check("unexpected_read", REQ_ADDR, 64'hFFFFFFFF);
        else begin
          re = exp_rd_q.pop_front();
          check("rd_addr", REQ_ADDR, re);
          check("rd_data_zero", REQ_DATA, 0);
        end
      end
    end
    if (RST && prev_stall)
      check("stall_hold", {10'b0, REQ_CS, REQ_WR, REQ_ADDR, REQ_DATA}, held);
    prev_stall = RST && REQ_CS && REQ_BUSY;
    held = {10'b0, REQ_CS, REQ_WR, REQ_ADDR, REQ_DATA};
    if (gap_en) begin
      gap = (rd_acc - rd_base) - (ack_cnt - ack_base);
      if (gap > max_gap) max_gap = gap;
    end
  end

  task automatic do_start(input logic [19:0] src, input logic [19:0] dst, input int len,
                          input logic [31:0] base, input bit fill);
    logic [19:0] sa, da;
    for (int i = 0; i < len; i++) begin
      sa = src + 20'(4 * i);
      da = dst + 20'(4 * i);
      if (!fill) begin
        mem[sa] = base + 32'(i);
        exp_rd_q.push_back(sa);
        exp_wr_q.push_back('{a: da, d: base + 32'(i)});
      end else begin
        exp_wr_q.push_back('{a: da, d: base});
      end
    end
    SRC_ADDR = src; DST_ADDR = dst; LEN = 16'(len);
`ifdef RCN_DMA_FILL_EN
    FILL = fill; FILL_DATA = base;
`endif
    START = 1'b1;
    tick(1);
    START = 1'b0;
`ifdef RCN_DMA_FILL_EN
    FILL = 1'b0;
`endif
  endtask

  task automatic wait_done(input string nm, input int budget, output int busy_cyc);
    int d0;
    bit got;
    d0 = done_cnt; busy_cyc = 0; got = 0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge CLK);
      if (BUSY) busy_cyc++;
      if (DONE) got = 1;
    end
    check({nm, "_done_seen"}, got, 1);
    tick(3);
    check({nm, "_done_once"}, done_cnt - d0, 1);
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_busy"}, BUSY, 0);
    check({nm, "_done"}, DONE, 0);
    check({nm, "_cs"}, REQ_CS, 0);
    check({nm, "_wr"}, REQ_WR, 0);
    check({nm, "_mask"}, REQ_MASK, 4'hF);
    check({nm, "_addr"}, REQ_ADDR, 0);
    check({nm, "_data"}, REQ_DATA, 0);
  endtask

  initial begin : main
    int bc, d0, w0;
    bit hit;
    tick(3);
    check_reset_outs("reset");
    RST = 1'b1;
    tick(2);

    // Basic copy
    do_start(20'h10000, 20'h10100, 4, 32'hA0, 0);
    check("basic_first_cs", REQ_CS, 1);
    check("basic_first_addr", REQ_ADDR, 20'h10000);
    check("basic_first_wr", REQ_WR, 0);
    check("basic_busy_c1", BUSY, 1);
    wait_done("basic", 100, bc);
    check("basic_busy_ge4", (bc >= 4), 1);
    for (int i = 0; i < 4; i++) check("basic_mem", mem[20'h10100 + 20'(4 * i)], 32'hA0 + 32'(i));

    // LEN = 0
    d0 = done_cnt;
    do_start(20'h10400, 20'h10500, 0, 32'h0, 0);
    check("len0_c1_cs", REQ_CS, 0);
    check("len0_c1_done", DONE, 0);
    check("len0_c1_busy", BUSY, 1);
    tick(1);
    check("len0_c2_done", DONE, 1);
    check("len0_c2_busy", BUSY, 0);
    check("len0_c2_cs", REQ_CS, 0);
    tick(1);
    check("len0_c3_done", DONE, 0);
    tick(2);
    check("len0_done_once", done_cnt - d0, 1);

    // Back-pressure
    rd_base = rd_acc; ack_base = ack_cnt; max_gap = 0;
    gap_en = 1; bp_en = 1;
    do_start(20'h11000, 20'h11100, 8, 32'hB0, 0);
    wait_done("bp", 400, bc);
    bp_en = 0; gap_en = 0;
    check("bp_gap_le_depth", (max_gap <= DEPTH), 1);
    for (int i = 0; i < 8; i++) check("bp_mem", mem[20'h11100 + 20'(4 * i)], 32'hB0 + 32'(i));

    // Address wrap: reads 0xFFFF8, 0xFFFFC, 0x00000, 0x00004
    do_start(20'hFFFF8, 20'h12000, 4, 32'hC0, 0);
    wait_done("wrap", 100, bc);
    check("wrap_mem0", mem[20'h12000], 32'hC0);
    check("wrap_mem3", mem[20'h1200C], 32'hC3);

    // Abort after 3 writes
    d0 = done_cnt; w0 = wr_acc; hit = 0;
    do_start(20'h13000, 20'h14000, 16, 32'hD0, 0);
    for (int c = 0; c < 300 && !hit; c++) begin
      if (wr_acc - w0 >= 3) hit = 1;
      else tick(1);
    end
    check("abort_3_writes_seen", hit, 1);
    RST = 1'b0;
    tick(1);
    check_reset_outs("abort");
    tick(1);
    exp_rd_q.delete();
    exp_wr_q.delete();
    RST = 1'b1;
    tick(1);
    inj = 1;
    @(negedge CLK); #2;
    inj = 0;
    tick(3);
    check("abort_idle_busy", BUSY, 0);
    check("abort_no_done", done_cnt - d0, 0);

    // Restart after abort
    do_start(20'h15000, 20'h16000, 2, 32'hE0, 0);
    wait_done("restart", 100, bc);
    check("restart_mem0", mem[20'h16000], 32'hE0);
    check("restart_mem1", mem[20'h16004], 32'hE1);

`ifdef RCN_DMA_FILL_EN
    // Fill mode
    w0 = rd_acc;
    do_start(20'h0, 20'h10200, 3, 32'hDEADBEEF, 1);
    wait_done("fill", 100, bc);
    check("fill_no_reads", rd_acc - w0, 0);
    for (int i = 0; i < 3; i++) check("fill_mem", mem[20'h10200 + 20'(4 * i)], 32'hDEADBEEF);
`endif

    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
